// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared widths, write-request type and source encoding for the write-port arbiter
package wb_port_arbiter_pkg;

  localparam int WIDTH   = 32;
  localparam int RADDR_W = 5;

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic [WIDTH-1:0]   data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_QUEUE,
    SRC_BYPASS
  } wb_src_e;

endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - power-of-two FIFO holding buffered MDU write requests
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter type T     = wb_req_t,
  parameter int  DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [DEPTH-1:0]         slot_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T mem [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two; count disambiguates full/empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

  // A slot is occupied when its distance from the read pointer is below count.
  always_comb begin
    slot_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot_valid[k] = {1'b0, PTR_W'(k) - rd_ptr} < count;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the register-file write port between pipeline writeback and queued MDU results
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W     = WIDTH,
  parameter int Q_DEPTH    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_wb_valid,
  input  logic [RADDR_W-1:0]    pipe_wb_rd,
  input  logic [DATA_W-1:0]     pipe_wb_data,
  output logic                  pipe_stall,
  input  logic                  mdu_valid,
  output logic                  mdu_ready,
  input  logic [RADDR_W-1:0]    mdu_rd,
  input  logic [DATA_W-1:0]     mdu_data,
  output logic                  rf_we,
  output logic [RADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [2**RADDR_W-1:0] pending_mask
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic [DATA_W-1:0]  data;
  } req_t;

  req_t               head;
  req_t               grant;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [Q_DEPTH-1:0] slot_valid;
  logic [RADDR_W-1:0] slot_rd [Q_DEPTH];
  logic [SW-1:0]      starve_cnt;
  logic [2**RADDR_W-1:0] mask_next;
  wb_src_e            src;
  logic               q_nonempty;
  logic               force_pop;
  logic               pop;
  logic               push;
  logic               bypass;

  wb_result_fifo #(
    .T     (req_t),
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  ({mdu_rd, mdu_data}),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .rd_ptr     (rd_ptr),
    .wr_ptr     (wr_ptr),
    .slot_valid (slot_valid)
  );

  assign q_nonempty = (count != '0);
  assign force_pop  = q_nonempty && (starve_cnt == SW'(STARVE_MAX));

  always_comb begin
    src = SRC_NONE;
    if (force_pop)          src = SRC_QUEUE;
    else if (pipe_wb_valid) src = SRC_PIPE;
    else if (q_nonempty)    src = SRC_QUEUE;
    else if (mdu_valid)     src = SRC_BYPASS;
  end

  always_comb begin
    grant = '0;
    case (src)
      SRC_PIPE:   grant = {pipe_wb_rd, pipe_wb_data};
      SRC_QUEUE:  grant = head;
      SRC_BYPASS: grant = {mdu_rd, mdu_data};
      default:    grant = '0;
    endcase
  end

  // x0 writes still consume their source; only the enable is suppressed.
  assign rf_we      = (src != SRC_NONE) && (grant.rd != '0);
  assign rf_waddr   = grant.rd;
  assign rf_wdata   = grant.data;
  assign pipe_stall = force_pop && pipe_wb_valid;

  assign pop       = (src == SRC_QUEUE);
  assign bypass    = (src == SRC_BYPASS);
  assign mdu_ready = (count < CNT_W'(Q_DEPTH)) || pop;
  assign push      = mdu_valid && mdu_ready && !bypass && (mdu_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (pop || !q_nonempty) begin
      starve_cnt <= '0;
    end else if ((src == SRC_PIPE) && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Destination shadow per slot so the mask can be rebuilt from post-edge occupancy.
  always_ff @(posedge clk) begin
    if (push) slot_rd[wr_ptr] <= mdu_rd;
  end

  always_comb begin
    mask_next = '0;
    for (int k = 0; k < Q_DEPTH; k++) begin
      if (slot_valid[k] && !(pop && (PTR_W'(k) == rd_ptr))) mask_next[slot_rd[k]] = 1'b1;
    end
    if (push) mask_next[mdu_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_mask <= '0;
    else        pending_mask <= mask_next;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter against a queue-based reference model
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        pipe_stall;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pipe_wb_valid (pipe_wb_valid),
    .pipe_wb_rd    (pipe_wb_rd),
    .pipe_wb_data  (pipe_wb_data),
    .pipe_stall    (pipe_stall),
    .mdu_valid     (mdu_valid),
    .mdu_ready     (mdu_ready),
    .mdu_rd        (mdu_rd),
    .mdu_data      (mdu_data),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .pending_mask  (pending_mask)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   mstarve;
  logic e_we, e_stall, e_ready;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  bit   m_pop, m_push, m_pipe_won, m_nonempty;

  task automatic model_reset();
    mq.delete();
    mstarve = 0;
  endtask

  // Evaluates the selection rules on the currently driven inputs.
  task automatic model_eval();
    bit byp = 0;
    bit any = 0;
    m_nonempty = (mq.size() != 0);
    m_pop = 0; m_pipe_won = 0; e_stall = 0; e_addr = 0; e_data = 0;
    if (m_nonempty && mstarve == 3) begin
      any = 1; m_pop = 1; e_addr = mq[0].rd; e_data = mq[0].data; e_stall = pipe_wb_valid;
    end else if (pipe_wb_valid) begin
      any = 1; m_pipe_won = 1; e_addr = pipe_wb_rd; e_data = pipe_wb_data;
    end else if (m_nonempty) begin
      any = 1; m_pop = 1; e_addr = mq[0].rd; e_data = mq[0].data;
    end else if (mdu_valid) begin
      any = 1; byp = 1; e_addr = mdu_rd; e_data = mdu_data;
    end
    e_we    = any && (e_addr != 0);
    e_ready = (mq.size() < 2) || m_pop;
    m_push  = mdu_valid && e_ready && !byp && (mdu_rd != 0);
  endtask

  task automatic model_commit();
    ent_t e;
    e.rd = mdu_rd; e.data = mdu_data;
    if (m_pop)  void'(mq.pop_front());
    if (m_push) mq.push_back(e);
    if (m_pop || !m_nonempty) mstarve = 0;
    else if (m_pipe_won && mstarve < 3) mstarve++;
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  task automatic step_drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                            input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    @(negedge clk);
    pipe_wb_valid = pv; pipe_wb_rd = prd; pipe_wb_data = pd;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    #1;
    model_eval();
  endtask

  task automatic step_clock();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic drive_idle();
    pipe_wb_valid = 0; pipe_wb_rd = 0; pipe_wb_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    vectors++;
    if ({rf_we, pipe_stall, mdu_ready, rf_waddr, rf_wdata, pending_mask} !== {1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got we=%b stall=%b ready=%b addr=%0d data=%h mask=%h, want 0 0 1 0 0 0",
               rf_we, pipe_stall, mdu_ready, rf_waddr, rf_wdata, pending_mask);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_bypass();
    step_drive(0, 0, 0, 1, 5'd5, 32'hAAAA_0001);
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata, mdu_ready, pipe_stall} !== {1'b1, 5'd5, 32'hAAAA_0001, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL bypass_out: got we=%b addr=%0d data=%h ready=%b stall=%b, want 1 5 aaaa0001 1 0",
               rf_we, rf_waddr, rf_wdata, mdu_ready, pipe_stall);
    end
    step_clock();
    vectors++;
    if (pending_mask !== 32'h0) begin
      miscompares++;
      $display("FAIL bypass_mask: got %h want 00000000", pending_mask);
    end
  endtask

  task automatic test_contention();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] pd = 32'h3000_0000 + 32'(i);
      logic [38:0] want;
      step_drive(1, 5'd3, pd, (i == 0), 5'd7, 32'h7777_0007);
      want = (i == 4) ? {1'b1, 1'b1, 5'd7, 32'h7777_0007} : {1'b1, 1'b0, 5'd3, pd};
      vectors++;
      if ({rf_we, pipe_stall, rf_waddr, rf_wdata} !== want) begin
        miscompares++;
        $display("FAIL contention_c%0d: got we=%b stall=%b addr=%0d data=%h, want %h",
                 i, rf_we, pipe_stall, rf_waddr, rf_wdata, want);
      end
      step_clock();
      vectors++;
      if (pending_mask !== ((i < 4) ? 32'h80 : 32'h0)) begin
        miscompares++;
        $display("FAIL contention_mask_c%0d: got %h want %h", i, pending_mask, (i < 4) ? 32'h80 : 32'h0);
      end
    end
  endtask

  task automatic test_full();
    logic [4:0]  ea [7] = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd10, 5'd11, 5'd12};
    logic [31:0] em [7] = '{32'h400, 32'hC00, 32'hC00, 32'hC00, 32'h1800, 32'h1000, 32'h0};
    logic [31:0] md [3] = '{32'hA0A0_000A, 32'hB0B0_000B, 32'hC0C0_000C};
    for (int i = 0; i < 7; i++) begin
      logic [31:0] pd = 32'h5000_0000 + 32'(i);
      logic [31:0] wd;
      int          k = (i < 2) ? i : 2;
      step_drive((i < 5), 5'd3, pd, (i <= 4), (i == 0) ? 5'd10 : (i == 1) ? 5'd11 : 5'd12, md[k]);
      wd = (i < 4) ? pd : md[i - 4];
      vectors++;
      if ({rf_we, pipe_stall, mdu_ready, rf_waddr, rf_wdata} !== {1'b1, (i == 4), !(i == 2 || i == 3), ea[i], wd}) begin
        miscompares++;
        $display("FAIL full_c%0d: got we=%b stall=%b ready=%b addr=%0d data=%h, want 1 %b %b %0d %h",
                 i, rf_we, pipe_stall, mdu_ready, rf_waddr, rf_wdata, (i == 4), !(i == 2 || i == 3), ea[i], wd);
      end
      step_clock();
      vectors++;
      if (pending_mask !== em[i]) begin
        miscompares++;
        $display("FAIL full_mask_c%0d: got %h want %h", i, pending_mask, em[i]);
      end
    end
  endtask

  task automatic test_x0();
    step_drive(1, 5'd0, 32'hDEAD_0000, 0, 0, 0);
    vectors++;
    if ({rf_we, pipe_stall} !== 2'b00) begin
      miscompares++;
      $display("FAIL x0_pipe: got we=%b stall=%b want 0 0", rf_we, pipe_stall);
    end
    step_clock();
    step_drive(1, 5'd3, 32'h0000_0333, 1, 5'd0, 32'hDEAD_0001);
    vectors++;
    if ({mdu_ready, rf_we, rf_waddr} !== {1'b1, 1'b1, 5'd3}) begin
      miscompares++;
      $display("FAIL x0_mdu_accept: got ready=%b we=%b addr=%0d want 1 1 3", mdu_ready, rf_we, rf_waddr);
    end
    step_clock();
    vectors++;
    if (pending_mask !== 32'h0) begin
      miscompares++;
      $display("FAIL x0_mask: got %h want 00000000", pending_mask);
    end
    step_drive(0, 0, 0, 0, 0, 0);
    vectors++;
    if (rf_we !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_not_queued: got we=%b want 0", rf_we);
    end
    step_clock();
    step_drive(0, 0, 0, 1, 5'd0, 32'hDEAD_0002);
    vectors++;
    if ({rf_we, mdu_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL x0_bypass: got we=%b ready=%b want 0 1", rf_we, mdu_ready);
    end
    step_clock();
  endtask

  task automatic test_dup();
    logic [31:0] d [2] = '{32'h9999_0001, 32'h9999_0002};
    for (int i = 0; i < 4; i++) begin
      logic [36:0] want = (i < 2) ? {5'd3, 32'h6000_0000 + 32'(i)} : {5'd9, d[i - 2]};
      step_drive((i < 2), 5'd3, 32'h6000_0000 + 32'(i), (i < 2), 5'd9, d[i % 2]);
      vectors++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, want}) begin
        miscompares++;
        $display("FAIL dup_c%0d: got we=%b addr=%0d data=%h want 1 %h", i, rf_we, rf_waddr, rf_wdata, want);
      end
      step_clock();
      vectors++;
      if (pending_mask !== ((i < 3) ? 32'h200 : 32'h0)) begin
        miscompares++;
        $display("FAIL dup_mask_c%0d: got %h want %h", i, pending_mask, (i < 3) ? 32'h200 : 32'h0);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_drive(1, 5'd3, 32'h1, 1, 5'd20, 32'h2020_2020);
    step_clock();
    step_drive(1, 5'd3, 32'h2, 1, 5'd21, 32'h2121_2121);
    step_clock();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    #1;
    vectors++;
    if ({rf_we, pipe_stall, mdu_ready, pending_mask} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_mid: got we=%b stall=%b ready=%b mask=%h want 0 0 1 0", rf_we, pipe_stall, mdu_ready, pending_mask);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_drive(0, 0, 0, 0, 0, 0);
      vectors++;
      if (rf_we !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_discard_c%0d: got we=%b addr=%0d want no write", i, rf_we, rf_waddr);
      end
      step_clock();
    end
  endtask

  task automatic test_random();
    logic        mv = 0, hold = 0, pv;
    logic [4:0]  mrd = 0, prd;
    logic [31:0] md = 0, pd;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        mv  = ($urandom_range(0, 99) < 55);
        mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        md  = $urandom;
      end
      pv  = ($urandom_range(0, 99) < 60);
      prd = 5'($urandom_range(0, 31));
      pd  = $urandom;
      step_drive(pv, prd, pd, mv, mrd, md);
      vectors++;
      if ({rf_we, pipe_stall, mdu_ready, rf_waddr, rf_wdata} !== {e_we, e_stall, e_ready, e_addr, e_data}) begin
        miscompares++;
        $display("FAIL random_out_%0d: got we=%b stall=%b ready=%b addr=%0d data=%h, want %b %b %b %0d %h",
                 n, rf_we, pipe_stall, mdu_ready, rf_waddr, rf_wdata, e_we, e_stall, e_ready, e_addr, e_data);
      end
      hold = mv && !e_ready;
      step_clock();
      vectors++;
      if (pending_mask !== model_mask()) begin
        miscompares++;
        $display("FAIL random_mask_%0d: got %h want %h", n, pending_mask, model_mask());
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_contention();
    test_full();
    test_x0();
    test_dup();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between two sources. The first is the in-order pipeline writeback, whose data is already chosen from ALU, MEM or PC+4. The second is the out-of-band multi-cycle unit (MDU: mul/div), which completes asynchronously to the pipeline. MDU results are buffered in a small queue. The pipeline has priority, with a starvation guard that forces a queue drain by stalling the writeback stage. The block sits between the writeback select logic and the register file.

Parameters:
DATA_W, WIDTH (package constant), register data width
RADDR_W, 5, register index width
Q_DEPTH, 2, MDU result queue entries (power of 2, ≥2)
STARVE_MAX, 3, consecutive lost cycles before the queue head is force-granted

Ports:
clk  in  1  system clock
rst_n  in  1  reset
pipe_wb_valid  in  1  pipeline WB stage holds an instruction with reg_write
pipe_wb_rd  in  RADDR_W  pipeline destination register
pipe_wb_data  in  DATA_W  selected writeback data
pipe_stall  out  1  hold the WB stage this cycle; write not performed
mdu_valid  in  1  MDU result available
mdu_ready  out  1  arbiter accepts the MDU result this cycle
mdu_rd  in  RADDR_W  MDU destination register
mdu_data  in  DATA_W  MDU result
rf_we  out  1  register file write enable
rf_waddr  out  RADDR_W  register file write address
rf_wdata  out  DATA_W  register file write data
pending_mask  out  2**RADDR_W  bit r set while any queued entry targets r (scoreboard input)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset behaviour:
  - Queue empties; pointers and count go to 0; starve_cnt goes to 0.
  - Outputs at reset: rf_we=0, pipe_stall=0, mdu_ready=1, pending_mask=0; rf_waddr and rf_wdata are 0.
  - Reset asserted mid-operation discards queued results with no write.
- Sources and write-port outputs:
  - The write port outputs are combinational from the current-cycle grant. Zero latency: a granted write lands at the next clk edge.
  - Source selection, evaluated each cycle:
    1. Force: queue non-empty and starve_cnt==STARVE_MAX → grant queue head; pipe_stall=pipe_wb_valid.
    2. Else pipe_wb_valid → grant pipeline; pipe_stall=0.
    3. Else queue non-empty → grant queue head.
    4. Else mdu_valid → bypass: grant the MDU input directly; it is not enqueued.
    5. Else no write.
- x0 handling:
  - Any grant with rd==0 gives rf_we=0, but the source is still consumed: the pipeline is not stalled, and the queue pops.
  - An MDU result with rd==0 is accepted and dropped, never enqueued.
- MDU handshake:
  - mdu_ready = (count<Q_DEPTH) || queue pops this cycle.
  - Transfer happens on mdu_valid && mdu_ready. mdu_rd and mdu_data must be held stable while mdu_valid && !mdu_ready.
  - A transfer is enqueued unless it is bypassed or has rd==0.
  - Enqueue and pop in the same cycle with a full queue: count stays unchanged, with no overflow.
- Starvation counter:
  - starve_cnt increments when the queue is non-empty and the pipeline wins the grant.
  - It resets to 0 on any queue pop or when the queue is empty, and saturates at STARVE_MAX.
- pending_mask:
  - Registered; it reflects the queue contents after the edge.
  - Duplicate rd entries keep the bit set until the last matching entry pops.
  - The bypass path never sets a bit.
- Ordering:
  - The queue is strict FIFO.
  - WAW between a queued MDU result and a younger pipeline write to the same rd is prevented upstream via pending_mask. The arbiter does not check it.
- Pointer wrap: pointers wrap modulo Q_DEPTH. Full/empty is tracked by count (width clog2(Q_DEPTH)+1).

Decomposition:
- Shared package (all_pkgs): WIDTH; RADDR_W; typedef wb_req_t {rd, data}; enum wb_src_e {SRC_NONE, SRC_PIPE, SRC_QUEUE, SRC_BYPASS}.
- Sub-module wb_result_fifo: generic Q_DEPTH×wb_req_t FIFO with push/pop/count, async active-low reset.
- Arbitration, starvation counter and pending_mask stay in the top module.

Test Plan:
- Bypass: queue empty, no pipe; mdu_valid rd=5 data=0xAAAA_0001 → same cycle rf_we=1, waddr=5, wdata=0xAAAA_0001, mdu_ready=1, pending_mask=0.
- Contention: pipe_wb_valid rd=3 every cycle; MDU pushes rd=7 → pipe writes for 3 cycles. Cycle 4: pipe_stall=1, rf_waddr=7, pending_mask[7] 1→0. Cycle 5: pipe rd=3 writes.
- Full queue: 2 MDU results queued under constant pipe traffic, third mdu_valid → mdu_ready=0. On force-pop cycle, mdu_ready=1; third result enqueued; count stays 2.
- x0: pipe rd=0 → rf_we=0, pipe_stall=0; MDU rd=0 accepted → never enqueued, no write, mask unchanged.
- Duplicate rd: queue two MDU results with rd=9 → pending_mask[9] stays 1 after first pop, clears after second. Writes occur in FIFO order (first data, then second).
- Reset mid-operation: queue holds 2 entries, rst_n low for 1 cycle → count=0, pending_mask=0, rf_we=0. Queued data is never written.
